// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory responder with byte/half/word access and alignment checking
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Busy,
    output logic        AlignError
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] cnt;
    logic rd_q, wr_q, uns_q, err, accept, unused_addr;
    logic [1:0] sz_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wd_q, wd_sh, word, ext, rd_hold, rd_nx;
    logic [3:0] lanes;
    logic [7:0] bval;
    logic [15:0] hval;
    logic [31:0] mem [2**(ADDR_W-2)];
    assign unused_addr = ^Address[31:ADDR_W];
    assign accept = state == IDLE && (MemoryRead || MemoryWrite);
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = accept ? (LATENCY == 0 ? DONE : WAIT) : IDLE;
            WAIT:    state_nx = cnt == 3'd1 ? DONE : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        err = (rd_q && wr_q) || sz_q == 2'b11 || (sz_q == 2'b01 && addr_q[0]) ||
              (sz_q == 2'b10 && addr_q[1:0] != 2'b00);
        word = mem[addr_q[ADDR_W-1:2]];
        bval = word[{addr_q[1:0], 3'b000} +: 8];
        hval = word[{addr_q[1], 4'b0000} +: 16];
        ext = sz_q == 2'b00 ? {{24{~uns_q & bval[7]}}, bval} :
              sz_q == 2'b01 ? {{16{~uns_q & hval[15]}}, hval} : word;
        lanes = sz_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                sz_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_sh = sz_q == 2'b00 ? {4{wd_q[7:0]}} : sz_q == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
        // loads and rejected requests update the result; stores leave it alone
        rd_nx = state == DONE && (err || !wr_q) ? (err ? 32'd0 : ext) : rd_hold;
    end
    assign ReadData   = rd_nx;
    assign Ready      = state == DONE;
    assign Busy       = state != IDLE;
    assign AlignError = Ready && err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_hold <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= accept ? 3'(LATENCY) : state == WAIT ? cnt - 3'd1 : cnt;
            rd_hold <= rd_nx;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q   <= MemoryRead;
            wr_q   <= MemoryWrite;
            sz_q   <= Size;
            uns_q  <= Unsigned;
            addr_q <= Address[ADDR_W-1:0];
            wd_q   <= WriteData;
        end
    end
    always_ff @(posedge clk) begin
        if (state == DONE && wr_q && !err)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= wd_sh[8*i +: 8];
    end
endmodule
